// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: state encodings, widths,
// default boot address and the PC legality helper.
package instr_fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // A fetch address is usable only if word aligned and the whole word
  // lies inside the instruction memory.
  function automatic logic pc_is_legal(input logic [31:0] pc,
                                       input logic [31:0] last_word);
    return (pc[1:0] == 2'b00) && (pc <= last_word);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with its next-PC mux (reset / +4 / redirect / hold).
module if_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_e     sel_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next-PC selection; +4 wraps modulo 2^32 and range is policed upstream.
  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:      pc_d = pc_q + 32'd4;
      PC_REDIRECT: pc_d = redirect_pc_i;
      default:     pc_d = pc_q;
    endcase
  end

  // PC register, forced to the boot address by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the ROM address from the PC, captures the
// returned word into the IF/ID register and sequences BOOT/FETCH/HALTED.
//
// Handshake: valid_o says the IF/ID register holds an instruction; decode
// consumes it on a rising edge where valid_o && id_ready_i. While valid_o is
// high and id_ready_i is low, instr_o/pc_o/pc_plus4_o stay stable and no new
// word is fetched. redirect_i flushes the register regardless of id_ready_i.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic               halt_i,
  input  logic               id_ready_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               fault_o,
  output logic [1:0]         state_o
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  fetch_state_e       state_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_out_q;
  logic [31:0]        pc_plus4_q;
  logic               fault_q;

  logic [31:0]        pc_q;
  logic               pc_legal;
  logic               capture;
  pc_sel_e            pc_sel;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .sel_i         (pc_sel),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_q)
  );

  // Capture decision and next-PC selection; redirect outranks capture/stall.
  always_comb begin
    pc_legal = pc_is_legal(pc_q, LAST_WORD);
    capture  = (state_q == FETCH) && (!valid_q || id_ready_i) &&
               !redirect_i && pc_legal;
    pc_sel   = PC_HOLD;
    if (state_q == FETCH) begin
      if (redirect_i)   pc_sel = PC_REDIRECT;
      else if (capture) pc_sel = PC_INC;
    end
  end

  // State machine, IF/ID register and sticky fault, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        BOOT:   state_q <= FETCH;
        FETCH: begin
          if (halt_i) state_q <= HALTED;
          if (!redirect_i && !pc_legal) begin
            fault_q <= 1'b1;
            state_q <= HALTED;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= BOOT;
      endcase

      if ((state_q == FETCH) && redirect_i) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q    <= 1'b1;
        instr_q    <= imem_rdata_i;
        pc_out_q   <= pc_q;
        pc_plus4_q <= pc_q + 32'd4;
      end else if (valid_q && id_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign pc_plus4_o  = pc_plus4_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule
